// File: rtl/usb_tx_if.sv
// usb_tx_if: byte handshake carrying tx_data/tx_valid/tx_last from master and tx_ready back from slave
interface usb_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  modport master (output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: double-buffered bytes from tx shifted out LSB-first on d_orig every BIT_CYCLES clks (bit_tick), held by pause, ending with eop_req or tx_underrun pulses
module usb_tx_serializer #(
  parameter int BIT_CYCLES = 8
) (
  input  logic   clk,
  input  logic   rst,
  usb_tx_if.slave tx,
  input  logic   pause,
  output logic   d_orig,
  output logic   bit_tick,
  output logic   tx_active,
  output logic   eop_req,
  output logic   tx_underrun
);
  localparam int TW = $clog2(BIT_CYCLES);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0] sr, sr_n, hold, hold_n;
  logic [2:0] idx, idx_n;
  logic last_q, last_n, hold_full, hold_full_n, hold_last, hold_last_n;
  logic eop_n, und_n, accept, byte_end, direct;
  assign tx.tx_ready = !hold_full;
  assign tx_active = state == SHIFT;
  assign bit_tick = tx_active && timer == TW'(BIT_CYCLES - 1);
  assign d_orig = tx_active ? sr[0] : 1'b1;
  assign accept = tx.tx_valid && !hold_full;
  assign byte_end = bit_tick && !pause && idx == 3'd7;
  assign direct = byte_end && !last_q && accept;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      sr <= '0;
      idx <= '0;
      last_q <= 1'b0;
      hold <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      eop_req <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      sr <= sr_n;
      idx <= idx_n;
      last_q <= last_n;
      hold <= hold_n;
      hold_full <= hold_full_n;
      hold_last <= hold_last_n;
      eop_req <= eop_n;
      tx_underrun <= und_n;
    end
  end
  // A last byte always closes its packet; anything already buffered belongs to the next packet and restarts from IDLE.
  always_comb begin
    state_n = state;
    timer_n = '0;
    sr_n = sr;
    idx_n = idx;
    last_n = last_q;
    hold_n = hold;
    hold_full_n = hold_full;
    hold_last_n = hold_last;
    eop_n = 1'b0;
    und_n = 1'b0;
    if (state == IDLE) begin
      if (hold_full || tx.tx_valid) begin
        state_n = SHIFT;
        sr_n = hold_full ? hold : tx.tx_data;
        last_n = hold_full ? hold_last : tx.tx_last;
        idx_n = '0;
        hold_full_n = 1'b0;
      end
    end else begin
      timer_n = bit_tick ? '0 : timer + 1'b1;
      if (accept && !direct) begin
        hold_n = tx.tx_data;
        hold_last_n = tx.tx_last;
        hold_full_n = 1'b1;
      end
      if (bit_tick && !pause) begin
        if (idx != 3'd7) begin
          sr_n = sr >> 1;
          idx_n = idx + 3'd1;
        end else if (last_q) begin
          state_n = IDLE;
          timer_n = '0;
          eop_n = 1'b1;
        end else if (hold_full || tx.tx_valid) begin
          sr_n = hold_full ? hold : tx.tx_data;
          last_n = hold_full ? hold_last : tx.tx_last;
          idx_n = '0;
          hold_full_n = 1'b0;
        end else begin
          state_n = IDLE;
          timer_n = '0;
          und_n = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: token scoreboard (bits, EOP=2, underrun=3) with directed and random packets under random pause
module tb_usb_tx_serializer;
  localparam int BC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  logic d_orig, bit_tick, tx_active, eop_req, tx_underrun;
  bit rand_pause = 1'b0;
  int checks = 0;
  int passes = 0;
  int q[$];
  usb_tx_if bus();
  usb_tx_serializer #(.BIT_CYCLES(BC)) dut (
    .clk(clk),
    .rst(rst),
    .tx(bus),
    .pause(pause),
    .d_orig(d_orig),
    .bit_tick(bit_tick),
    .tx_active(tx_active),
    .eop_req(eop_req),
    .tx_underrun(tx_underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask
  initial forever begin
    @(posedge clk);
    #1 pause = rand_pause && ($urandom_range(0, 3) == 0);
  end
  initial begin : monitor
    int cnt, tok;
    bit end_due, acc_idle, acc_busy;
    logic [7:0] acc_d;
    cnt = 0;
    end_due = 0;
    acc_idle = 0;
    acc_busy = 0;
    acc_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
        end_due = 0;
        acc_idle = 0;
        acc_busy = 0;
        continue;
      end
      if (acc_idle) begin
        chk("start_active", tx_active, 1);
        chk("start_bit0", d_orig, acc_d[0]);
      end
      if (acc_busy) chk("ready_fall", bus.tx_ready, 0);
      chk("end_pulse", eop_req | tx_underrun, end_due);
      end_due = 0;
      if (eop_req || tx_underrun) begin
        chk("end_idle", {d_orig, tx_active}, 2);
        tok = q.size() != 0 ? q.pop_front() : -1;
        chk(eop_req ? "eop_token" : "underrun_token", tok, eop_req ? 2 : 3);
      end
      chk("tick_phase", bit_tick, tx_active && (cnt % BC == BC - 1));
      cnt = tx_active ? cnt + 1 : 0;
      if (bit_tick && !pause) begin
        tok = q.size() != 0 ? q.pop_front() : -1;
        chk("data_bit", d_orig, tok);
        end_due = q.size() != 0 ? q[0] >= 2 : 1'b0;
      end
      acc_idle = bus.tx_valid && bus.tx_ready && !tx_active;
      acc_busy = bus.tx_valid && bus.tx_ready && tx_active && !(bit_tick && !pause);
      acc_d = bus.tx_data;
    end
  end
  task automatic push_byte(input logic [7:0] d, input bit l);
    for (int i = 0; i < 8; i++) q.push_back(int'(d[i]));
    if (l) q.push_back(2);
  endtask
  task automatic send(input logic [7:0] d, input bit l);
    int n = 0;
    bus.tx_data = d;
    bus.tx_last = l;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("accept_timeout", 0, 1);
      bus.tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
    push_byte(d, l);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || tx_active) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 5000, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_d_orig"}, d_orig, 1);
    chk({tag, "_ready"}, bus.tx_ready, 1);
    chk({tag, "_tick"}, bit_tick, 0);
    chk({tag, "_active"}, tx_active, 0);
    chk({tag, "_eop"}, eop_req, 0);
    chk({tag, "_underrun"}, tx_underrun, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, n, len;
    bit und;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    bus.tx_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'hA5, 1);
    wait_idle();
    send(8'h01, 0);
    send(8'hFF, 1);
    wait_idle();
    rand_pause = 1'b1;
    send(8'hFE, 1);
    wait_idle();
    send(8'h3C, 0);
    q.push_back(3);
    wait_idle();
    send(8'h3A, 0);
    k = 0;
    n = 0;
    while (k < 8 && n < 1000) begin
      @(posedge clk);
      #2;
      if (bit_tick && !pause) begin
        k++;
        if (k == 8) begin
          bus.tx_data = 8'h55;
          bus.tx_last = 1'b1;
          bus.tx_valid = 1'b1;
        end
      end
      n++;
    end
    chk("direct_tick_found", k, 8);
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
    push_byte(8'h55, 1);
    wait_idle();
    rand_pause = 1'b0;
    send(8'hC3, 0);
    repeat (14) @(posedge clk);
    chk("pre_rst_active", tx_active, 1);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(8'h80, 1);
    wait_idle();
    rand_pause = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 4);
      und = $urandom_range(0, 3) == 0;
      for (int b = 0; b < len; b++) send(8'($urandom), (b == len - 1) && !und);
      if (und) begin
        q.push_back(3);
        wait_idle();
      end
    end
    wait_idle();
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
